// File: rtl/drum_pkg.sv
// Shared defaults and state encoding for the drum step sequencer.
package drum_pkg;

  localparam int unsigned DEF_NUM_TRACKS = 4;
  localparam int unsigned DEF_NUM_STEPS  = 16;
  localparam int unsigned DEF_STEP_W     = 4;
  localparam int unsigned DEF_TRIG_LEN   = 2;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Steps shorter than the trigger plus one low tick would merge adjacent pulses.
  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] min_len);
    return (len < min_len) ? min_len : len;
  endfunction

endpackage

// File: rtl/drum_pattern_ram.sv
// Track x step on/off pattern: synchronous write, combinational column read.
module drum_pattern_ram
  import drum_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = DEF_NUM_TRACKS,
  parameter int unsigned NUM_STEPS  = DEF_NUM_STEPS,
  parameter int unsigned STEP_W     = DEF_STEP_W,
  parameter int unsigned TRK_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [TRK_W-1:0]      wr_track_i,
  input  logic [STEP_W-1:0]     wr_step_i,
  input  logic                  wr_data_i,
  input  logic [STEP_W-1:0]     rd_step_i,
  output logic [NUM_TRACKS-1:0] rd_col_o
);

  logic [NUM_STEPS-1:0] row_q [NUM_TRACKS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
        row_q[t] <= '0;
      end
    end else if (wr_en_i) begin
      row_q[wr_track_i][wr_step_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_col_o = '0;
    for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
      rd_col_o[t] = row_q[t][rd_step_i];
    end
  end

endmodule

// File: rtl/drum_step_sequencer.sv
// Pattern-driven step sequencer clocked by the audio tick; one trigger per drum track.
module drum_step_sequencer
  import drum_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = DEF_NUM_TRACKS,
  parameter int unsigned NUM_STEPS  = DEF_NUM_STEPS,
  parameter int unsigned STEP_W     = DEF_STEP_W,
  parameter int unsigned TRIG_LEN   = DEF_TRIG_LEN,
  parameter int unsigned TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                  audio_tick,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [15:0]           step_len,
  input  logic [NUM_TRACKS-1:0] mute,
  input  logic                  wr_en,
  input  logic [TRK_W-1:0]      wr_track,
  input  logic [STEP_W-1:0]     wr_step,
  input  logic                  wr_data,
  output logic [NUM_TRACKS-1:0] trigger,
  output logic [STEP_W-1:0]     step_idx,
  output logic                  bar_pulse,
  output logic                  running
);

  localparam int unsigned TC_W    = $clog2(TRIG_LEN + 1);
  localparam logic [15:0] MIN_LEN = 16'(TRIG_LEN + 1);

  seq_state_e            state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [15:0]           tick_q, tick_d;
  logic [15:0]           len_q, len_d;
  logic [TC_W-1:0]       trig_cnt_q, trig_cnt_d;
  logic [NUM_TRACKS-1:0] trig_q, trig_d;
  logic                  bar_q, bar_d;
  logic [NUM_TRACKS-1:0] col;

  drum_pattern_ram #(
    .NUM_TRACKS(NUM_TRACKS),
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W),
    .TRK_W     (TRK_W)
  ) u_ram (
    .clk_i     (audio_tick),
    .rst_ni    (reset_n),
    .wr_en_i   (wr_en),
    .wr_track_i(wr_track),
    .wr_step_i (wr_step),
    .wr_data_i (wr_data),
    .rd_step_i (step_q),
    .rd_col_o  (col)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tick_d     = tick_q;
    len_d      = len_q;
    trig_cnt_d = trig_cnt_q;
    trig_d     = trig_q;
    bar_d      = 1'b0;

    if (!run) begin
      state_d    = STOP;
      step_d     = '0;
      tick_d     = '0;
      trig_cnt_d = '0;
      trig_d     = '0;
    end else begin
      state_d = RUN;
      if (trig_cnt_q != '0) begin
        trig_cnt_d = trig_cnt_q - TC_W'(1);
      end else begin
        trig_d = '0;
      end

      // STOP always sits at step 0 / tick 0, so starting is just a fire of step 0.
      if (state_q == STOP || tick_q == '0) begin
        trig_d     = col & ~mute;
        trig_cnt_d = TC_W'(TRIG_LEN - 1);
        tick_d     = 16'd1;
        bar_d      = (step_q == '0);
        len_d      = clamp_len(step_len, MIN_LEN);
      end else if (tick_q == len_q - 16'd1) begin
        tick_d = '0;
        step_d = step_q + STEP_W'(1);
      end else begin
        tick_d = tick_q + 16'd1;
      end
    end
  end

  always_ff @(posedge audio_tick or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= STOP;
      step_q     <= '0;
      tick_q     <= '0;
      len_q      <= MIN_LEN;
      trig_cnt_q <= '0;
      trig_q     <= '0;
      bar_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tick_q     <= tick_d;
      len_q      <= len_d;
      trig_cnt_q <= trig_cnt_d;
      trig_q     <= trig_d;
      bar_q      <= bar_d;
    end
  end

  assign trigger   = trig_q;
  assign step_idx  = step_q;
  assign bar_pulse = bar_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed and randomized stimulus against a tick-age reference model of the sequencer.
module tb_drum_step_sequencer;

  localparam int NT = 4;
  localparam int NS = 16;
  localparam int SW = 4;
  localparam int TL = 2;

  logic          audio_tick = 1'b0;
  logic          reset_n    = 1'b0;
  logic          run        = 1'b0;
  logic [15:0]   step_len   = 16'd8;
  logic [NT-1:0] mute       = '0;
  logic          wr_en      = 1'b0;
  logic [1:0]    wr_track   = '0;
  logic [SW-1:0] wr_step    = '0;
  logic          wr_data    = 1'b0;
  logic [NT-1:0] trigger;
  logic [SW-1:0] step_idx;
  logic          bar_pulse;
  logic          running;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  // Reference model: time since the last fire ("age") drives everything.
  bit            pat [NT][NS];
  bit            m_run;
  int unsigned   m_step, m_age, m_len;
  logic [NT-1:0] m_mask;
  bit            m_bar;

  drum_step_sequencer #(
    .NUM_TRACKS(NT),
    .NUM_STEPS (NS),
    .STEP_W    (SW),
    .TRIG_LEN  (TL)
  ) dut (
    .audio_tick(audio_tick),
    .reset_n   (reset_n),
    .run       (run),
    .step_len  (step_len),
    .mute      (mute),
    .wr_en     (wr_en),
    .wr_track  (wr_track),
    .wr_step   (wr_step),
    .wr_data   (wr_data),
    .trigger   (trigger),
    .step_idx  (step_idx),
    .bar_pulse (bar_pulse),
    .running   (running)
  );

  always #5 audio_tick = ~audio_tick;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++)
      for (int s = 0; s < NS; s++)
        pat[t][s] = 1'b0;
    m_run  = 1'b0;
    m_step = 0;
    m_age  = 0;
    m_len  = TL + 1;
    m_mask = '0;
    m_bar  = 1'b0;
  endtask

  task automatic model_fire();
    for (int t = 0; t < NT; t++)
      m_mask[t] = pat[t][m_step] & ~mute[t];
    m_bar = (m_step == 0);
    m_len = (int'(step_len) < TL + 1) ? TL + 1 : int'(step_len);
    m_age = 0;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (run) begin
        m_run  = 1'b1;
        m_step = 0;
        model_fire();
      end
    end else if (!run) begin
      m_run  = 1'b0;
      m_step = 0;
      m_age  = 0;
      m_mask = '0;
      m_bar  = 1'b0;
    end else begin
      m_age++;
      if (m_age == m_len) begin
        m_step = (m_step + 1) % NS;
        model_fire();
      end
    end
    // Pattern update after the fire so a same-edge write is seen next pass.
    if (wr_en) pat[wr_track][wr_step] = wr_data;
  endtask

  task automatic check_outputs();
    logic [NT-1:0] exp_trig;
    int unsigned   exp_step;
    exp_trig = (m_run && m_age < TL) ? m_mask : '0;
    exp_step = !m_run ? 0 : ((m_age >= m_len - 1) ? (m_step + 1) % NS : m_step);
    check("trigger",   32'(trigger),   32'(exp_trig));
    check("step_idx",  32'(step_idx),  exp_step);
    check("bar_pulse", 32'(bar_pulse), 32'(m_run && m_age == 0 && m_bar));
    check("running",   32'(running),   32'(m_run));
  endtask

  task automatic tick();
    @(posedge audio_tick);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_cell(input int tr, input int st, input bit d);
    wr_en    = 1'b1;
    wr_track = 2'(tr);
    wr_step  = SW'(st);
    wr_data  = d;
    tick();
    wr_en    = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs();
    #10 reset_n = 1'b1;

    // Sparse pattern on track 0, step_len 8, one full bar plus the wrap.
    for (int s = 0; s < NS; s += 4) write_cell(0, s, 1'b1);
    run = 1'b1;
    tick();
    check("start_trig0", 32'(trigger[0]), 32'd1);
    check("start_bar",   32'(bar_pulse),  32'd1);
    ticks(129);

    // Minimum step length: track 1 all ones gives a 1,1,0 trigger rhythm.
    run = 1'b0;
    tick();
    for (int s = 0; s < NS; s += 4) write_cell(0, s, 1'b0);
    for (int s = 0; s < NS; s++) write_cell(1, s, 1'b1);
    step_len = 16'd0;
    run = 1'b1;
    ticks(30);

    // Mute on track 2 at step 0, released mid-bar.
    run = 1'b0;
    tick();
    for (int s = 0; s < NS; s++) write_cell(1, s, 1'b0);
    write_cell(2, 0, 1'b1);
    write_cell(2, 8, 1'b1);
    step_len = 16'd8;
    mute     = 4'b0100;
    run      = 1'b1;
    tick();
    check("mute_trig2", 32'(trigger[2]), 32'd0);
    ticks(20);
    mute = '0;
    ticks(50);

    // Write pattern[3][5] on the very edge step 5 fires.
    run = 1'b0;
    tick();
    write_cell(2, 0, 1'b0);
    write_cell(2, 8, 1'b0);
    run = 1'b1;
    tick();
    ticks(39);
    write_cell(3, 5, 1'b1);
    check("wr_fire_old", 32'(trigger[3]), 32'd0);
    ticks(127);
    tick();
    check("wr_fire_new", 32'(trigger[3]), 32'd1);

    // Stop during an active trigger at step 6, then restart.
    run = 1'b0;
    tick();
    write_cell(3, 6, 1'b1);
    run = 1'b1;
    tick();
    ticks(48);
    check("step6_trig3", 32'(trigger[3]), 32'd1);
    run = 1'b0;
    tick();
    check("stop_trig", 32'(trigger), 32'd0);
    check("stop_step", 32'(step_idx), 32'd0);
    run = 1'b1;
    tick();
    check("restart_step", 32'(step_idx), 32'd0);
    check("restart_bar",  32'(bar_pulse), 32'd1);

    // Randomized stretch.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 3) run = ~run;
      if ($urandom_range(0, 99) < 5) step_len = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 99) < 8) mute = NT'($urandom);
      wr_en    = ($urandom_range(0, 99) < 30);
      wr_track = 2'($urandom_range(0, NT - 1));
      wr_step  = SW'($urandom);
      wr_data  = 1'($urandom);
      tick();
    end
    wr_en = 1'b0;

    // Asynchronous reset between edges while running.
    run      = 1'b1;
    mute     = '0;
    step_len = 16'd4;
    ticks(10);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("areset_trig",    32'(trigger),   32'd0);
    check("areset_step",    32'(step_idx),  32'd0);
    check("areset_bar",     32'(bar_pulse), 32'd0);
    check("areset_running", 32'(running),   32'd0);
    @(negedge audio_tick);
    reset_n = 1'b1;
    ticks(40);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
